matrix_ctrl: RTL

MATRIX_CTRL -- requirements
Module: matrix_ctrl

---
 rtl/matrix_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/matrix_ctrl.sv
// Sequencer for an external 5x5 byte-matrix ALU: it loads A (and B for binary ops),
// pulses the opcode to the ALU for one cycle, captures the result and streams it out.
module matrix_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_opcode,
  input  logic [8:0]   cmd_factor,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic [199:0] alu_A_flat,
  output logic [199:0] alu_B_flat,
  output logic [3:0]   alu_opcode,
  output logic [8:0]   alu_f,
  input  logic [199:0] alu_C_flat,
  output logic         busy,
  output logic         error
);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, CAPTURE, SEND} state_t;

  state_t         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [199:0]   a_q, a_d, b_q, b_d, r_q, r_d;
  logic [3:0]     op_q, op_d;
  logic [8:0]     f_q, f_d;
  logic           err_q, err_d;
  logic [7:0]     bit_idx;
  logic           cnt_last, cmd_binary, cmd_unary, op_binary;

  assign bit_idx    = {cnt_q, 3'b000};
  assign cnt_last   = (cnt_q == 5'd24);
  assign cmd_binary = (cmd_opcode >= 4'd1) && (cmd_opcode <= 4'd3);
  assign cmd_unary  = (cmd_opcode >= 4'd4) && (cmd_opcode <= 4'd6);
  assign op_binary  = (op_q >= 4'd1) && (op_q <= 4'd3);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    op_d    = op_q;
    f_d     = f_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_binary || cmd_unary) begin
            op_d    = cmd_opcode;
            f_d     = cmd_factor;
            err_d   = 1'b0;
            cnt_d   = 5'd0;
            state_d = LOAD_A;
            // Unary ops never load B; clear it so the ALU never sees stale data.
            if (cmd_unary) b_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD_A: begin
        if (in_valid) begin
          a_d[bit_idx +: 8] = in_data;
          cnt_d = cnt_last ? 5'd0 : cnt_q + 5'd1;
          if (cnt_last) state_d = op_binary ? LOAD_B : EXEC;
        end
      end
      LOAD_B: begin
        if (in_valid) begin
          b_d[bit_idx +: 8] = in_data;
          cnt_d = cnt_last ? 5'd0 : cnt_q + 5'd1;
          if (cnt_last) state_d = EXEC;
        end
      end
      EXEC:    state_d = CAPTURE;
      CAPTURE: begin
        r_d     = alu_C_flat;
        state_d = SEND;
      end
      SEND: begin
        if (out_ready) begin
          cnt_d = cnt_last ? 5'd0 : cnt_q + 5'd1;
          if (cnt_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      op_q    <= '0;
      f_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      op_q    <= op_d;
      f_q     <= f_d;
      err_q   <= err_d;
    end
  end

  // The ALU keys off a non-zero opcode, so it is shown only during the single EXEC cycle.
  assign alu_opcode = (state_q == EXEC) ? op_q : 4'd0;
  assign alu_A_flat = a_q;
  assign alu_B_flat = b_q;
  assign alu_f      = f_q;

  assign cmd_ready  = (state_q == IDLE) && !rst;
  assign in_ready   = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign out_valid  = (state_q == SEND);
  assign out_data   = r_q[bit_idx +: 8];
  assign busy       = (state_q != IDLE);
  assign error      = err_q;

endmodule
